// File: rtl/line_stream_feeder_pkg.sv
// Shared constants for the tile raster feeder: FSM encoding and size limits.
package line_stream_feeder_pkg;

  localparam logic [1:0] SIdle  = 2'b00;
  localparam logic [1:0] SRead  = 2'b01;
  localparam logic [1:0] SFlush = 2'b11;
  localparam logic [1:0] SDone  = 2'b10;

  localparam int unsigned MaxDim    = 416;
  localparam int unsigned MinRow    = 5;
  localparam int unsigned FlushTail = 2;

endpackage

// File: rtl/line_stream_feeder_raster_counter.sv
// Row/col raster counter: row wraps at row_last and bumps col; term_c flags a chosen position.
module raster_counter #(
  parameter int unsigned RowWidth = 9,
  parameter int unsigned ColWidth = 9
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                step,
  input  logic [RowWidth-1:0] row_last,
  input  logic [RowWidth-1:0] term_row,
  input  logic [ColWidth-1:0] term_col,
  output logic [RowWidth-1:0] row,
  output logic [ColWidth-1:0] col,
  output logic                row_end_c,
  output logic                term_c
);

  assign row_end_c = (row == row_last);
  assign term_c    = (row == term_row) && (col == term_col);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      row <= '0;
      col <= '0;
    end else if (step) begin
      if (row_end_c) begin
        row <= '0;
        col <= col + ColWidth'(1);
      end else begin
        row <= row + RowWidth'(1);
      end
    end
  end

endmodule

// File: rtl/line_stream_feeder.sv
// Streams one tile from RAM in raster order with aligned counts, then zero flush beats
// so the 3x3 window generator can emit its bottom-padding windows.
module line_stream_feeder
  import line_stream_feeder_pkg::*;
#(
  parameter int unsigned DataWidth   = 64,
  parameter int unsigned MaxRowWidth = 9,
  parameter int unsigned MaxColWidth = 9,
  parameter int unsigned AddrWidth   = 18
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic                   start,
  input  logic [AddrWidth-1:0]   base_addr,
  input  logic [MaxRowWidth-1:0] row_in,
  input  logic [MaxColWidth-1:0] col_in,
  output logic                   rd_en,
  output logic [AddrWidth-1:0]   rd_addr,
  input  logic [DataWidth-1:0]   rd_data,
  output logic [DataWidth-1:0]   data_out,
  output logic [MaxRowWidth-1:0] row_count,
  output logic [MaxColWidth-1:0] col_count,
  output logic                   stream_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   size_err
);

  logic [1:0]             state, state_next;
  logic [MaxRowWidth-1:0] row_last;
  logic [MaxColWidth-1:0] col_lines;
  logic [MaxRowWidth-1:0] cnt_row;
  logic [MaxColWidth-1:0] cnt_col;
  logic                   row_end_c, term_c;
  logic                   real_beat, last_beat;
  logic                   legal_c, accept_c, reject_c, issue_c, read_last_c;

  assign legal_c = (row_in >= MaxRowWidth'(MinRow)) && (row_in <= MaxRowWidth'(MaxDim)) &&
                   (col_in != '0) && (col_in <= MaxColWidth'(MaxDim));

  // Issue stage stops once the terminal beat has moved into the output stage.
  assign issue_c     = (state == SRead) || ((state == SFlush) && !last_beat);
  assign read_last_c = row_end_c && (cnt_col == col_lines - MaxColWidth'(1));

  raster_counter #(
    .RowWidth(MaxRowWidth),
    .ColWidth(MaxColWidth)
  ) u_counter (
    .clk      (Clk),
    .rst_n    (Rst_n),
    .clear    (accept_c),
    .step     (issue_c),
    .row_last (row_last),
    .term_row (MaxRowWidth'(FlushTail - 1)),
    .term_col (col_lines + MaxColWidth'(1)),
    .row      (cnt_row),
    .col      (cnt_col),
    .row_end_c(row_end_c),
    .term_c   (term_c)
  );

  always_comb begin
    state_next = state;
    accept_c   = 1'b0;
    reject_c   = 1'b0;
    case (state)
      SIdle: begin
        if (start) begin
          if (legal_c) begin
            accept_c   = 1'b1;
            state_next = SRead;
          end else begin
            reject_c = 1'b1;
          end
        end
      end
      SRead:   if (read_last_c) state_next = SFlush;
      SFlush:  if (last_beat) state_next = SDone;
      SDone:   state_next = SIdle;
      default: state_next = SIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) state <= SIdle;
    else        state <= state_next;
  end

  // Output stage lags the issue stage by one cycle to line up with RAM read latency.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      row_last     <= '0;
      col_lines    <= '0;
      rd_en        <= 1'b0;
      rd_addr      <= '0;
      stream_valid <= 1'b0;
      row_count    <= '0;
      col_count    <= '0;
      real_beat    <= 1'b0;
      last_beat    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      size_err     <= 1'b0;
    end else begin
      if (accept_c) begin
        row_last  <= row_in - MaxRowWidth'(1);
        col_lines <= col_in;
      end
      rd_en <= (state_next == SRead);
      if (state_next == SRead) rd_addr <= (state == SIdle) ? base_addr : rd_addr + AddrWidth'(1);
      else                     rd_addr <= '0;
      stream_valid <= issue_c;
      row_count    <= issue_c ? cnt_row : '0;
      col_count    <= issue_c ? cnt_col : '0;
      real_beat    <= issue_c && (state == SRead);
      last_beat    <= issue_c && term_c;
      busy         <= (state_next == SRead) || (state_next == SFlush);
      done         <= (state_next == SDone);
      size_err     <= reject_c;
    end
  end

  assign data_out = real_beat ? rd_data : '0;

endmodule

// File: tb/tb_line_stream_feeder.sv
// Directed table-driven bench for line_stream_feeder with a 1-cycle-latency RAM model.
module tb_line_stream_feeder;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        start;
  logic [17:0] base_addr;
  logic [8:0]  row_in;
  logic [8:0]  col_in;
  logic        rd_en;
  logic [17:0] rd_addr;
  logic [63:0] rd_data;
  logic [63:0] data_out;
  logic [8:0]  row_count;
  logic [8:0]  col_count;
  logic        stream_valid, busy, done, size_err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int unsigned row;
    int unsigned col;
    int unsigned base;
    int unsigned inject_at;
    int unsigned reset_at;
    bit          illegal;
  } vec_t;

  vec_t vecs[13];

  line_stream_feeder dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .start       (start),
    .base_addr   (base_addr),
    .row_in      (row_in),
    .col_in      (col_in),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .data_out    (data_out),
    .row_count   (row_count),
    .col_count   (col_count),
    .stream_valid(stream_valid),
    .busy        (busy),
    .done        (done),
    .size_err    (size_err)
  );

  always #5 Clk = ~Clk;

  // RAM[a] = a; garbage when not read so missing flush zeroing shows up.
  always @(posedge Clk) rd_data <= rd_en ? 64'(rd_addr) : 64'hBAD0_BAD0_BAD0_BAD0;

  function automatic logic [127:0] pack(input logic en, input logic [17:0] addr, input logic vld,
                                        input logic [8:0] r, input logic [8:0] c,
                                        input logic [63:0] d, input logic bsy,
                                        input logic dn, input logic err);
    return 128'({en, addr, vld, r, c, d, bsy, dn, err});
  endfunction

  task automatic check(input string name, input int k, input logic [127:0] act,
                       input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle S+%0d: got %h expected %h", name, k, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input string name);
    int unsigned total, nreads, last_k, b;
    logic        e_en, e_vld, e_bsy, e_dn, e_err;
    logic [17:0] e_addr;
    logic [8:0]  e_r, e_c;
    logic [63:0] e_d;
    total  = (v.col + 1) * v.row + 2;
    nreads = v.row * v.col;
    last_k = v.illegal ? 5 : total + 4;
    @(negedge Clk);
    row_in    = 9'(v.row);
    col_in    = 9'(v.col);
    base_addr = 18'(v.base);
    start     = 1'b1;
    for (int k = 1; k <= int'(last_k); k++) begin
      @(negedge Clk);
      start = 1'b0;
      Rst_n = 1'b1;
      e_en = 0; e_addr = '0; e_vld = 0; e_r = '0; e_c = '0; e_d = '0;
      e_bsy = 0; e_dn = 0; e_err = 0;
      if (v.illegal) begin
        e_err = (k == 1);
      end else if (v.reset_at != 0 && k == int'(v.reset_at) + 1) begin
        check({name, "_reset"}, k,
              pack(rd_en, rd_addr, stream_valid, row_count, col_count, data_out,
                   busy, done, size_err), 128'd0);
        break;
      end else begin
        if (k >= 1 && k - 1 < int'(nreads)) begin
          e_en   = 1;
          e_addr = 18'(v.base + k - 1);
        end
        if (k >= 2 && k - 2 < int'(total)) begin
          b     = k - 2;
          e_vld = 1;
          e_r   = 9'(b % v.row);
          e_c   = 9'(b / v.row);
          e_d   = (b / v.row < v.col) ? 64'(18'(v.base + b)) : 64'd0;
        end
        e_bsy = (k >= 1) && (k <= int'(total) + 1);
        e_dn  = (k == int'(total) + 2);
      end
      check(name, k,
            pack(rd_en, rd_addr, stream_valid, row_count, col_count, data_out,
                 busy, done, size_err),
            pack(e_en, e_addr, e_vld, e_r, e_c, e_d, e_bsy, e_dn, e_err));
      if (k == int'(v.inject_at)) begin
        start     = 1'b1;
        row_in    = 9'd6;
        base_addr = 18'h2000;
      end
      if (k == int'(v.reset_at)) Rst_n = 1'b0;
    end
    Rst_n = 1'b1;
    repeat (2) @(negedge Clk);
  endtask

  initial begin
    vecs[0]  = '{8, 4, 32'h100, 0, 0, 0};
    vecs[1]  = '{8, 4, 32'h100, 10, 0, 0};
    vecs[2]  = '{8, 4, 32'h100, 44, 0, 0};
    vecs[3]  = '{8, 4, 32'h100, 0, 21, 0};
    vecs[4]  = '{8, 4, 32'h100, 0, 0, 0};
    vecs[5]  = '{5, 1, 32'h3FFF0, 0, 0, 0};
    vecs[6]  = '{416, 2, 32'h20, 0, 0, 0};
    vecs[7]  = '{5, 416, 32'h0, 0, 0, 0};
    vecs[8]  = '{4, 4, 32'h100, 0, 0, 1};
    vecs[9]  = '{8, 0, 32'h100, 0, 0, 1};
    vecs[10] = '{417, 3, 32'h100, 0, 0, 1};
    vecs[11] = '{5, 417, 32'h100, 0, 0, 1};
    vecs[12] = '{5, 5, 32'h7, 0, 0, 0};

    Rst_n = 1'b0; start = 1'b0; base_addr = '0; row_in = '0; col_in = '0;
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    check("reset_idle", 0,
          pack(rd_en, rd_addr, stream_valid, row_count, col_count, data_out,
               busy, done, size_err), 128'd0);

    for (int i = 0; i < 13; i++) run(vecs[i], $sformatf("vec%0d", i));

    // Reset during the flush tail: no done pulse, then a clean replay.
    run('{8, 4, 32'h40, 0, 38, 0}, "reset_in_flush");
    run('{8, 4, 32'h40, 0, 0, 0}, "replay_after_flush_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
